i3c_tgt_sdr_rx: RTL and testbench
=================================

# i3c_tgt_sdr_rx

Synthesizable I3C SDR target-side frame receiver. It watches the controller-driven SCL/SDA pins from I3C_TOP and detects START, Repeated START and STOP. It ACKs the 7'h7E broadcast and its own static address, then delivers received data words with T-bit parity checking. It also flags entry into HDR mode on the ENTHDR0 CCC (0x20), so the downstream checks now done by hand in the bench run in RTL, and the same block serves as the target front-end.

## Interface
- STATIC_ADDR, 7'h08, target's own 7-bit static address.
- SYNC_STAGES, 2, pin synchronizer depth (2 or 3 only).
- i_sdr_clk  in  1  system clock (≥8× SCL rate).
- i_sdr_rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- i_tgt_en  in  1  receiver enable; 0 forces IDLE and releases SDA.
- i_scl  in  1  raw SCL pin.
- i_sda  in  1  raw SDA pin (resolved open-drain value).
- o_sda_low  out  1  open-drain pull-down enable for SDA (1 = drive 0, 0 = Z).
- o_rx_data  out  8  last received data byte, MSB first on bus.
- o_rx_valid  out  1  one-cycle strobe: o_rx_data/o_rx_ccc/o_parity_err valid.
- o_rx_ccc  out  1  marks the first word after an ACKed broadcast write as a CCC code.
- o_parity_err  out  1  T bit failed odd parity for this word.
- o_addr_hit  out  2  00 none, 01 broadcast 7E/W, 10 static address match; held until STOP.
- o_hdr_mode  out  1  high from accepted ENTHDR0 until STOP.
- o_busy  out  1  high between START and STOP.

## Operation
- Synchronize SCL/SDA through SYNC_STAGES flops, then register once more for edge detection. All decisions use the synchronized values.
- START/Sr means SDA falls while SCL is high. STOP means SDA rises while SCL is high. SDA changes with SCL low are data transitions.
- FSM states:
  - IDLE: on START go to ADDR, bit counter = 0.
  - ADDR: shift SDA on each SCL rising edge. After 8 bits, compare {addr, RnW}:
    - {7E, 0} → hit = 01, go to ACK.
    - {STATIC_ADDR, any} → hit = 10, go to ACK.
    - Anything else → NACK_WAIT; SDA stays released until STOP/Sr.
  - ACK: on the next SCL falling edge assert o_sda_low, go to ACK_HOLD.
  - ACK_HOLD: release o_sda_low on the following SCL falling edge, go to DATA, counter = 0.
  - DATA: shift 9 bits on SCL rising edges (8 data, then T). On the 9th bit:
    - Pulse o_rx_valid.
    - o_parity_err = ~(^{data, T}) (odd parity).
    - o_rx_ccc = 1 only for the first word after hit 01.
    - If that CCC word is 0x20 with parity OK → HDR. Otherwise stay in DATA for the next word.
  - HDR: bus ignored; o_hdr_mode = 1 until STOP.
- START/Sr seen in any state except IDLE → ADDR. Sr clears o_addr_hit and o_hdr_mode is unaffected only by STOP (Sr inside HDR is ignored).
- STOP in any state → IDLE; clears o_addr_hit, o_hdr_mode, o_busy, o_sda_low.
- Read transactions (RnW = 1 on static hit) are ACKed, then treated as NACK_WAIT. Read data is out of scope.

## Timing
- Reset values: o_sda_low 0, o_rx_data 0, o_rx_valid 0, o_rx_ccc 0, o_parity_err 0, o_addr_hit 00, o_hdr_mode 0, o_busy 0; FSM in IDLE.
- Edge detect latency: SYNC_STAGES+1 clocks from a raw pin edge.
- o_rx_valid: asserted exactly one clock after the detected SCL rising edge of the T bit, high for 1 clock.
- o_sda_low asserts 1 clock after the detected SCL falling edge that ends the RnW bit. It deasserts 1 clock after the next detected SCL falling edge, so it is held for one full SCL period.
- Simultaneous START and SCL edge cannot occur (START requires SCL high and stable). STOP takes priority over a pending ACK.
- i_tgt_en low takes effect within 1 clock: IDLE, all outputs at reset values.
- Async reset mid-frame: outputs go to reset values immediately. After release, stay in IDLE until a fresh START.

## Structure
- Shared package i3c_tgt_pkg: FSM state enum, BROADCAST_ADDR = 7'h7E, CCC_ENTHDR0 = 8'h20, hit encodings.
- One sub-module, i3c_bus_cond_det: synchronizer plus SCL rise/fall and START/STOP detection. The FSM, shift register and counter stay in the top.

## Test plan
- START, 7E+W, then 0x20 with T = 0 → ACK low for one SCL period; o_rx_valid with data 0x20, o_rx_ccc = 1, parity_err 0; o_hdr_mode = 1 until STOP.
- START, 7E+W, then 0x20 with T = 1 → parity_err = 1; o_hdr_mode stays 0.
- START, addr 0x08+W, then words 0xA5/T = 1 and 0x3C/T = 1 → hit 10; two valids; rx_ccc 0; no parity errors.
- START, addr 0x33+W → no ACK (SDA stays at pullup); hit 00; no valids until STOP.
- Broadcast, then Sr mid-word, then 0x08+W → partial word dropped; new ACK; hit switches 01 → 10.
- Reset pulsed during ACK_HOLD → o_sda_low drops immediately; the next transaction completes normally.

Source files
------------

// File: rtl/i3c_tgt_pkg.sv
// Shared types and constants for the I3C SDR target receiver.
// Imported by the receiver top and its bench-facing logic.
package i3c_tgt_pkg;

    localparam logic [6:0] BROADCAST_ADDR = 7'h7E;
    localparam logic [7:0] CCC_ENTHDR0    = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_ACK_HOLD,
        ST_DATA,
        ST_HDR,
        ST_NACK_WAIT
    } rx_state_e;

    typedef enum logic [1:0] {
        HIT_NONE   = 2'b00,
        HIT_BCAST  = 2'b01,
        HIT_STATIC = 2'b10
    } addr_hit_e;

    // A word plus its T bit must carry an odd number of ones.
    function automatic logic odd_parity_bad(input logic [7:0] data, input logic t);
        return ~(^{data, t});
    endfunction

endpackage

// File: rtl/i3c_bus_cond_det.sv
// Pin synchronizer for SCL/SDA with SCL edge and START/STOP detection.
// Detection is masked until the pipeline holds real pin samples after reset.
module i3c_bus_cond_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda_sync
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic [SYNC_STAGES:0]   fill_q, fill_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   primed;

    assign scl_s  = scl_sync_q[SYNC_STAGES-1];
    assign sda_s  = sda_sync_q[SYNC_STAGES-1];
    assign primed = fill_q[SYNC_STAGES];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        fill_d     = {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            fill_q     <= '0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            fill_q     <= fill_d;
        end
    end

    // SDA edges only count as bus conditions while SCL is stably high.
    assign o_scl_rise = primed & scl_s & ~scl_prev_q;
    assign o_scl_fall = primed & ~scl_s & scl_prev_q;
    assign o_start    = primed & scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign o_stop     = primed & scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign o_sda_sync = sda_s;

endmodule

// File: rtl/i3c_tgt_sdr_rx.sv
// I3C SDR target frame receiver: address match, ACK, T-bit checked words,
// CCC tagging and ENTHDR0 detection.
module i3c_tgt_sdr_rx
    import i3c_tgt_pkg::*;
#(
    parameter logic [6:0]  STATIC_ADDR = 7'h08,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_sdr_clk,
    input  logic       i_sdr_rst_n,
    input  logic       i_tgt_en,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_low,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_ccc,
    output logic       o_parity_err,
    output logic [1:0] o_addr_hit,
    output logic       o_hdr_mode,
    output logic       o_busy
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    rx_state_e state_q, state_d;
    addr_hit_e hit_q, hit_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       rnw_q, rnw_d;
    logic       first_q, first_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ccc_q, rx_ccc_d;
    logic       perr_q, perr_d;
    logic       hdr_q, hdr_d;
    logic       busy_q, busy_d;

    i3c_bus_cond_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
        .i_clk      (i_sdr_clk),
        .i_rst_n    (i_sdr_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (start_det),
        .o_stop     (stop_det),
        .o_sda_sync (sda_s)
    );

    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        rnw_d      = rnw_q;
        first_d    = first_q;
        sda_low_d  = sda_low_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ccc_d   = rx_ccc_q;
        perr_d     = perr_q;
        hdr_d      = hdr_q;
        busy_d     = busy_q;

        if (!i_tgt_en) begin
            state_d   = ST_IDLE;
            hit_d     = HIT_NONE;
            cnt_d     = 4'd0;
            shreg_d   = 8'd0;
            rnw_d     = 1'b0;
            first_d   = 1'b0;
            sda_low_d = 1'b0;
            rx_data_d = 8'd0;
            rx_ccc_d  = 1'b0;
            perr_d    = 1'b0;
            hdr_d     = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            hit_d     = HIT_NONE;
            sda_low_d = 1'b0;
            hdr_d     = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det && state_q != ST_HDR) begin
            state_d   = ST_ADDR;
            hit_d     = HIT_NONE;
            cnt_d     = 4'd0;
            shreg_d   = 8'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        // Eighth bit is RnW; the address is already in shreg.
                        if (cnt_q == 4'd7) begin
                            rnw_d = sda_s;
                            if (shreg_q[6:0] == BROADCAST_ADDR && !sda_s) begin
                                hit_d   = HIT_BCAST;
                                state_d = ST_ACK;
                            end else if (shreg_q[6:0] == STATIC_ADDR) begin
                                hit_d   = HIT_STATIC;
                                state_d = ST_ACK;
                            end else begin
                                state_d = ST_NACK_WAIT;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b1;
                        state_d   = ST_ACK_HOLD;
                    end
                end
                ST_ACK_HOLD: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        cnt_d     = 4'd0;
                        first_d   = 1'b1;
                        state_d   = rnw_q ? ST_NACK_WAIT : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d      = 4'd0;
                            first_d    = 1'b0;
                            rx_valid_d = 1'b1;
                            rx_data_d  = shreg_q;
                            perr_d     = odd_parity_bad(shreg_q, sda_s);
                            rx_ccc_d   = first_q && (hit_q == HIT_BCAST);
                            if (rx_ccc_d && shreg_q == CCC_ENTHDR0 && !perr_d) begin
                                hdr_d   = 1'b1;
                                state_d = ST_HDR;
                            end
                        end else begin
                            shreg_d = {shreg_q[6:0], sda_s};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                ST_IDLE, ST_HDR, ST_NACK_WAIT: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            state_q    <= ST_IDLE;
            hit_q      <= HIT_NONE;
            cnt_q      <= 4'd0;
            shreg_q    <= 8'd0;
            rnw_q      <= 1'b0;
            first_q    <= 1'b0;
            sda_low_q  <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_ccc_q   <= 1'b0;
            perr_q     <= 1'b0;
            hdr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_q      <= hit_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            rnw_q      <= rnw_d;
            first_q    <= first_d;
            sda_low_q  <= sda_low_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ccc_q   <= rx_ccc_d;
            perr_q     <= perr_d;
            hdr_q      <= hdr_d;
            busy_q     <= busy_d;
        end
    end

    assign o_sda_low    = sda_low_q;
    assign o_rx_data    = rx_data_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_rx_ccc     = rx_ccc_q;
    assign o_parity_err = perr_q;
    assign o_addr_hit   = hit_q;
    assign o_hdr_mode   = hdr_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_i3c_tgt_sdr_rx.sv
// Bench for i3c_tgt_sdr_rx: bit-banged controller, scoreboard of expected
// words and a monitor that pops one entry per o_rx_valid strobe.
module tb_i3c_tgt_sdr_rx;

    localparam logic [6:0] STATIC = 7'h08;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       ctl_scl = 1'b1;
    logic       ctl_sda = 1'b1;
    logic       bus_sda;
    logic       sda_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ccc;
    logic       perr;
    logic [1:0] hit;
    logic       hdr;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ccc;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] wd[8];
    logic       wt[8];

    assign bus_sda = ctl_sda & ~sda_low;

    always #5 clk = ~clk;

    i3c_tgt_sdr_rx #(
        .STATIC_ADDR(STATIC),
        .SYNC_STAGES(2)
    ) dut (
        .i_sdr_clk    (clk),
        .i_sdr_rst_n  (rst_n),
        .i_tgt_en     (en),
        .i_scl        (ctl_scl),
        .i_sda        (bus_sda),
        .o_sda_low    (sda_low),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_rx_ccc     (rx_ccc),
        .o_parity_err (perr),
        .o_addr_hit   (hit),
        .o_hdr_mode   (hdr),
        .o_busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rx_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got data %0h ccc %0b perr %0b, none expected",
                         rx_data, rx_ccc, perr);
            end else begin
                mon_e = sb.pop_front();
                if ({rx_data, rx_ccc, perr} !== mon_e) begin
                    n_fail++;
                    $display("FAIL rx_word: got %0h/%0b/%0b expected %0h/%0b/%0b",
                             rx_data, rx_ccc, perr, mon_e.data, mon_e.ccc, mon_e.perr);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_c();
        ctl_sda = 1'b0;
        tick(10);
        ctl_scl = 1'b0;
    endtask

    task automatic rstart_c();
        tick(3);
        ctl_sda = 1'b1;
        tick(7);
        ctl_scl = 1'b1;
        tick(10);
        ctl_sda = 1'b0;
        tick(10);
        ctl_scl = 1'b0;
    endtask

    task automatic stop_c();
        tick(3);
        ctl_sda = 1'b0;
        tick(7);
        ctl_scl = 1'b1;
        tick(10);
        ctl_sda = 1'b1;
        tick(10);
    endtask

    task automatic send_bit(input logic b);
        tick(3);
        ctl_sda = b;
        tick(7);
        ctl_scl = 1'b1;
        tick(10);
        ctl_scl = 1'b0;
    endtask

    task automatic ack_bit(output logic acked);
        tick(3);
        ctl_sda = 1'b1;
        tick(7);
        ctl_scl = 1'b1;
        tick(5);
        acked = (bus_sda == 1'b0);
        tick(5);
        ctl_scl = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        tick(5);
        check({tag, "_idle"}, {28'd0, sda_low, hit, hdr, busy}, 32'd0);
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    // Reference: ACK on 7E/W or the static address; words only on an
    // ACKed write; first broadcast word is a CCC; ENTHDR0 with good parity
    // ends word delivery.
    task automatic xfer(input logic [6:0] addr, input logic rnw, input int n,
                        input string tag);
        logic       bcast;
        logic       exp_ack;
        logic [1:0] exp_hit;
        logic       got;
        logic       hdr_m;
        logic       p_bad;
        bcast   = (addr == 7'h7E) && !rnw;
        exp_ack = bcast || (addr == STATIC);
        exp_hit = bcast ? 2'b01 : ((addr == STATIC) ? 2'b10 : 2'b00);
        for (int i = 6; i >= 0; i--) send_bit(addr[i]);
        send_bit(rnw);
        ack_bit(got);
        check({tag, "_ack"}, {31'd0, got}, {31'd0, exp_ack});
        check({tag, "_hit"}, {30'd0, hit}, {30'd0, exp_hit});
        tick(6);
        check({tag, "_ack_rel"}, {31'd0, sda_low}, 32'd0);
        hdr_m = 1'b0;
        for (int i = 0; i < n; i++) begin
            p_bad = ($countones({wd[i], wt[i]}) % 2) == 0;
            if (exp_ack && !rnw && !hdr_m) begin
                sb.push_back({wd[i], bcast && (i == 0), p_bad});
                if (bcast && i == 0 && wd[i] == 8'h20 && !p_bad) hdr_m = 1'b1;
            end
            for (int b = 7; b >= 0; b--) send_bit(wd[i][b]);
            send_bit(wt[i]);
        end
        tick(6);
        check({tag, "_hdr"}, {31'd0, hdr}, {31'd0, hdr_m});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        logic       got;
        logic [6:0] ra;
        logic       rr;
        int         nw;
        int         sel;

        tick(3);
        check("reset_state",
              {17'd0, sda_low, rx_data, rx_valid, rx_ccc, perr, hit, hdr, busy}, 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        tick(6);

        wd[0] = 8'h20; wt[0] = 1'b0;
        start_c();
        xfer(7'h7E, 1'b0, 1, "enthdr");
        stop_c();
        check_idle("enthdr");

        wd[0] = 8'h20; wt[0] = 1'b1;
        start_c();
        xfer(7'h7E, 1'b0, 1, "enthdr_bad");
        stop_c();
        check_idle("enthdr_bad");

        wd[0] = 8'hA5; wt[0] = 1'b1;
        wd[1] = 8'h3C; wt[1] = 1'b1;
        start_c();
        xfer(STATIC, 1'b0, 2, "static");
        stop_c();
        check_idle("static");

        wd[0] = 8'h55; wt[0] = 1'b1;
        start_c();
        xfer(7'h33, 1'b0, 1, "nomatch");
        stop_c();
        check_idle("nomatch");

        start_c();
        xfer(7'h7E, 1'b0, 0, "sr_a");
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rstart_c();
        check("sr_hit_clr", {30'd0, hit}, 32'd0);
        wd[0] = 8'h20; wt[0] = 1'b0;
        xfer(STATIC, 1'b0, 1, "sr_b");
        stop_c();
        check_idle("sr");

        start_c();
        for (int i = 6; i >= 0; i--) send_bit(STATIC[i]);
        send_bit(1'b0);
        tick(3);
        ctl_sda = 1'b1;
        tick(7);
        ctl_scl = 1'b1;
        tick(5);
        check("rst_pre_ack", {31'd0, sda_low}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {28'd0, sda_low, hit, hdr, busy}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        ctl_scl = 1'b0;
        stop_c();
        check_idle("rst");
        wd[0] = 8'h81; wt[0] = 1'b1;
        start_c();
        xfer(STATIC, 1'b0, 1, "post_rst");
        stop_c();
        check_idle("post_rst");

        start_c();
        for (int i = 6; i >= 0; i--) send_bit(STATIC[i]);
        send_bit(1'b0);
        ack_bit(got);
        en = 1'b0;
        tick(1);
        check("en_off", {28'd0, sda_low, hit, hdr, busy}, 32'd0);
        en = 1'b1;
        stop_c();
        check_idle("en");

        start_c();
        xfer(STATIC, 1'b1, 0, "read");
        stop_c();
        check_idle("read");

        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 3);
            ra  = (sel == 1) ? STATIC : ((sel == 2) ? 7'($urandom_range(0, 127)) : 7'h7E);
            rr  = ($urandom_range(0, 4) == 0);
            nw  = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                wd[i] = 8'($urandom_range(0, 255));
                if (i == 0 && $urandom_range(0, 1) == 1) wd[i] = 8'h20;
                wt[i] = ~(^wd[i]) ^ ($urandom_range(0, 3) == 0);
            end
            start_c();
            xfer(ra, rr, nw, "rand");
            stop_c();
            check_idle("rand");
        end

        tick(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
